// File: rtl/hack_boot_loader.sv
// Framed byte-stream loader: parses A5/count/data/checksum frames into program-memory writes and holds the CPU in reset until a verified image is loaded.
// Latency: ROM write strobe 1 cycle after each lo-byte handshake; done/cpu_reset change 1 cycle after the checksum handshake.
// Backpressure: rx_ready depends on state only; it is high in IDLE..CHECK and low in DONE/ERROR until a start pulse re-arms the loader.
module hack_boot_loader #(
    parameter int ADDR_W         = 15,
    parameter int MAX_WORDS      = 32768,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              rom_wr_en,
    output logic [ADDR_W-1:0] rom_wr_addr,
    output logic [15:0]       rom_wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [15:0]       words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       words_q, words_d;
    logic [7:0]        acc_q, acc_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [1:0]        code_q, code_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic        hs;
    logic        in_frame;
    logic        tmo_hit;
    logic        rearm;
    logic [15:0] cnt_full;

    assign hs       = rx_valid && rx_ready;
    assign in_frame = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    // Expiry on the same edge as a handshake loses to the byte.
    assign tmo_hit  = in_frame && !hs && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign rearm    = start && ((state_q == S_DONE) || (state_q == S_ERROR));
    assign cnt_full = {cnt_q[15:8], rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (hs && rx_data == 8'hA5) state_d = S_CNT_HI;
            S_CNT_HI:  if (hs) state_d = S_CNT_LO;
            S_CNT_LO:
                if (hs) begin
                    if (cnt_full == 16'd0 || 32'(cnt_full) > 32'(MAX_WORDS)) state_d = S_ERROR;
                    else                                                     state_d = S_DATA_HI;
                end
            S_DATA_HI: if (hs) state_d = S_DATA_LO;
            S_DATA_LO: if (hs) state_d = (words_q == cnt_q - 16'd1) ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (hs) state_d = (rx_data == acc_q) ? S_DONE : S_ERROR;
            S_DONE:    if (start) state_d = S_IDLE;
            S_ERROR:   if (start) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (tmo_hit) state_d = S_ERROR;
    end

    always_comb begin
        rx_ready  = in_frame || (state_q == S_IDLE);
        busy      = in_frame;
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERROR);
        cpu_reset = (state_q != S_DONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        words_d   = words_q;
        acc_d     = acc_q;
        code_d    = code_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tmo_d     = '0;
        if (in_frame && !hs) tmo_d = tmo_q + TW'(1);

        if (hs) begin
            unique case (state_q)
                S_CNT_HI:  cnt_d[15:8] = rx_data;
                S_CNT_LO:  cnt_d[7:0]  = rx_data;
                S_DATA_HI: begin
                    hi_d  = rx_data;
                    acc_d = acc_q + rx_data;
                end
                S_DATA_LO: begin
                    acc_d     = acc_q + rx_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = words_q[ADDR_W-1:0];
                    wr_data_d = {hi_q, rx_data};
                    words_d   = words_q + 16'd1;
                end
                default: ;
            endcase
        end

        if (state_d == S_ERROR && state_q != S_ERROR) begin
            if (!hs)                     code_d = 2'd3;
            else if (state_q == S_CNT_LO) code_d = 2'd1;
            else                          code_d = 2'd2;
        end

        if (rearm) begin
            cnt_d   = '0;
            words_d = '0;
            acc_d   = '0;
            code_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            words_q   <= '0;
            acc_q     <= '0;
            tmo_q     <= '0;
            code_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            words_q   <= words_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
            code_q    <= code_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rom_wr_en    = wr_en_q;
    assign rom_wr_addr  = wr_addr_q;
    assign rom_wr_data  = wr_data_q;
    assign error_code   = code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: frames, checksum/count/timeout errors, re-arm, random rx_valid gaps, mid-frame reset.
module tb_hack_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        rom_wr_en;
    logic [14:0] rom_wr_addr;
    logic [15:0] rom_wr_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    int          wr_total = 0;
    int          consec   = 0;
    logic        prev_en  = 1'b0;
    logic [14:0] log_addr [0:63];
    logic [15:0] log_data [0:63];

    hack_boot_loader #(
        .ADDR_W(15), .MAX_WORDS(32768), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .start(start),
        .rom_wr_en(rom_wr_en), .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_wr_en) begin
            if (wr_total < 64) begin
                log_addr[wr_total] = rom_wr_addr;
                log_data[wr_total] = rom_wr_data;
            end
            wr_total = wr_total + 1;
            if (prev_en) consec = consec + 1;
        end
        prev_en = rom_wr_en;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_rdy", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        send(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int base;
        logic [7:0]  fr [0:10];
        logic [15:0] wexp [0:3];

        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_wr_en",     {31'd0, rom_wr_en}, 32'd0);
        chk("rst_wr_addr",   {17'd0, rom_wr_addr}, 32'd0);
        chk("rst_wr_data",   {16'd0, rom_wr_data}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        chk("rst_error",     {31'd0, error}, 32'd0);
        chk("rst_code",      {30'd0, error_code}, 32'd0);
        chk("rst_words",     {16'd0, words_loaded}, 32'd0);
        chk("rst_rx_ready",  {31'd0, rx_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Good 2-word frame, checksum 0x10+0xEC+0x10 = 0x10C -> 0x0C
        send(8'hA5); send(8'h00); send(8'h02);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        send(8'h00); send(8'h10);
        chk("f1_w0_en",   {31'd0, rom_wr_en}, 32'd1);
        chk("f1_w0_addr", {17'd0, rom_wr_addr}, 32'd0);
        chk("f1_w0_data", {16'd0, rom_wr_data}, 32'h0010);
        chk("f1_w0_cnt",  {16'd0, words_loaded}, 32'd1);
        send(8'hEC);
        chk("f1_gap_en", {31'd0, rom_wr_en}, 32'd0);
        send(8'h10);
        chk("f1_w1_en",   {31'd0, rom_wr_en}, 32'd1);
        chk("f1_w1_addr", {17'd0, rom_wr_addr}, 32'd1);
        chk("f1_w1_data", {16'd0, rom_wr_data}, 32'hEC10);
        chk("f1_w1_cnt",  {16'd0, words_loaded}, 32'd2);
        send(8'h0C);
        chk("f1_done",      {31'd0, done}, 32'd1);
        chk("f1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("f1_busy_end",  {31'd0, busy}, 32'd0);
        chk("f1_rx_ready",  {31'd0, rx_ready}, 32'd0);
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("f1_done_hold", {31'd0, done}, 32'd1);
        chk("f1_words_hold", {16'd0, words_loaded}, 32'd2);
        pulse_start();
        chk("f1_rearm_done",  {31'd0, done}, 32'd0);
        chk("f1_rearm_cpu",   {31'd0, cpu_reset}, 32'd1);
        chk("f1_rearm_words", {16'd0, words_loaded}, 32'd0);

        // Same frame with wrong checksum
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h00); send(8'h10); send(8'hEC); send(8'h10);
        send(8'h0D);
        chk("f2_error",    {31'd0, error}, 32'd1);
        chk("f2_code",     {30'd0, error_code}, 32'd2);
        chk("f2_cpu",      {31'd0, cpu_reset}, 32'd1);
        chk("f2_rx_ready", {31'd0, rx_ready}, 32'd0);
        pulse_start();
        chk("f2_rearm_err",   {31'd0, error}, 32'd0);
        chk("f2_rearm_code",  {30'd0, error_code}, 32'd0);
        chk("f2_rearm_words", {16'd0, words_loaded}, 32'd0);
        chk("f2_rearm_rdy",   {31'd0, rx_ready}, 32'd1);

        // Junk before sync, then N=0; then N=32769
        base = wr_total;
        send(8'h55); send(8'h13);
        chk("f3_junk_busy", {31'd0, busy}, 32'd0);
        send(8'hA5); send(8'h00); send(8'h00);
        chk("f3_n0_error", {31'd0, error}, 32'd1);
        chk("f3_n0_code",  {30'd0, error_code}, 32'd1);
        chk("f3_no_writes", wr_total - base, 32'd0);
        pulse_start();
        send(8'hA5); send(8'h80); send(8'h01);
        chk("f3_big_code", {30'd0, error_code}, 32'd1);
        pulse_start();

        // Timeout: 99 idle cycles survive, 100 expire
        send(8'hA5);
        repeat (99) @(negedge clk);
        chk("f4_gap_err", {31'd0, error}, 32'd0);
        send(8'h00);
        chk("f4_gap_busy", {31'd0, busy}, 32'd1);
        send(8'h01); send(8'h00);
        repeat (99) @(negedge clk);
        chk("f4_99_err", {31'd0, error}, 32'd0);
        @(negedge clk);
        chk("f4_100_err",  {31'd0, error}, 32'd1);
        chk("f4_100_code", {30'd0, error_code}, 32'd3);
        chk("f4_100_cpu",  {31'd0, cpu_reset}, 32'd1);
        pulse_start();

        // 4-word frame with random rx_valid gaps; checksum 0xDA
        wexp[0] = 16'h1234; wexp[1] = 16'hABCD; wexp[2] = 16'h0F0F; wexp[3] = 16'hFFFF;
        fr[0] = 8'hA5; fr[1] = 8'h00; fr[2] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            fr[3 + 2*i] = wexp[i][15:8];
            fr[4 + 2*i] = wexp[i][7:0];
        end
        base = wr_total;
        for (int i = 0; i < 11; i++) send_gap(fr[i], int'($urandom_range(0, 3)));
        send_gap(8'hDA, int'($urandom_range(0, 3)));
        chk("f5_nwr", wr_total - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("f5_addr", {17'd0, log_addr[base + i]}, i);
            chk("f5_data", {16'd0, log_data[base + i]}, {16'd0, wexp[i]});
        end
        chk("f5_done", {31'd0, done}, 32'd1);
        pulse_start();

        // Reset mid-frame, then a full reload from address 0
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11); send(8'h11); send(8'h22); send(8'h22);
        chk("f6_pre_en", {31'd0, rom_wr_en}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("f6_arst_en",    {31'd0, rom_wr_en}, 32'd0);
        chk("f6_arst_cpu",   {31'd0, cpu_reset}, 32'd1);
        chk("f6_arst_busy",  {31'd0, busy}, 32'd0);
        chk("f6_arst_words", {16'd0, words_loaded}, 32'd0);
        chk("f6_arst_addr",  {17'd0, rom_wr_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(8'hA5); send(8'h00); send(8'h01); send(8'h01); send(8'h02);
        chk("f6_addr", {17'd0, rom_wr_addr}, 32'd0);
        chk("f6_data", {16'd0, rom_wr_data}, 32'h0102);
        send(8'h03);
        chk("f6_done", {31'd0, done}, 32'd1);
        chk("f6_cpu",  {31'd0, cpu_reset}, 32'd0);

        chk("no_consec_wr", consec, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
